uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-requester round-robin front end for a single UART
// transmitter. One byte is in flight at a time; a stuck transmitter is
// abandoned after TIMEOUT cycles and flagged on a sticky o_timeout.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT = 2000
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_data,
   output logic [3:0]  o_ack,
   output logic        o_tx_dv,
   output logic [7:0]  o_tx_byte,
   input  logic        i_tx_active,
   input  logic        i_tx_done,
   output logic [1:0]  o_grant_id,
   output logic        o_busy,
   output logic        o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_DRAIN     = 2'd3
   } state_t;

   // Last counter value allowed in WAIT_DONE before the transfer is abandoned.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic [1:0]  grant_q, grant_d;
   logic [3:0]  ack_q, ack_d;
   logic        tx_dv_q, tx_dv_d;
   logic        busy_q, busy_d;
   logic        timeout_q, timeout_d;
   logic [2:0]  pick_s;

   // Round-robin search starting just after the last grant; bit 2 = found.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
      logic [2:0] pick;
      logic [1:0] cand;
      pick = 3'b000;
      cand = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!pick[2] && req[cand]) begin
            pick = {1'b1, cand};
         end
      end
      return pick;
   endfunction

   // Winner candidate for the current request vector.
   always_comb begin
      pick_s = rr_pick(i_req, grant_q);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      byte_d    = byte_q;
      grant_d   = grant_q;
      timeout_d = timeout_q;
      tx_dv_d   = 1'b0;
      ack_d     = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (pick_s[2] && !i_tx_active && !i_tx_done) begin
               state_d = ST_ISSUE;
               byte_d  = i_data[{pick_s[1:0], 3'b000} +: 8];
               grant_d = pick_s[1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            tx_dv_d = 1'b1;
            ack_d   = 4'b0001 << grant_q;
            cnt_d   = 16'd0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            cnt_d = cnt_q + 16'd1;
            if (i_tx_done) begin
               // A done in the timeout cycle still counts as a normal finish.
               state_d = ST_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_DRAIN;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_DRAIN: begin
            // Hold off until the transmitter is quiet so a long done is not re-counted.
            if (i_tx_done || i_tx_active) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         byte_q    <= 8'h00;
         grant_q   <= 2'd3;
         ack_q     <= 4'b0000;
         tx_dv_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         byte_q    <= byte_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         tx_dv_q   <= tx_dv_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_ack      = ack_q;
   assign o_tx_dv    = tx_dv_q;
   assign o_tx_byte  = byte_q;
   assign o_grant_id = grant_q;
   assign o_busy     = busy_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter, compared every cycle.
module tb_uart_tx_arbiter;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [31:0] data = 32'h0;
   logic        tx_active = 1'b0;
   logic        tx_done = 1'b0;
   logic [3:0]  ack;
   logic        dv;
   logic [7:0]  tx_byte;
   logic [1:0]  gid;
   logic        busy;
   logic        to;

   uart_tx_arbiter #(.TIMEOUT(TO)) u_dut (
      .i_Clock(clk), .i_Reset(rst), .i_req(req), .i_data(data),
      .o_ack(ack), .o_tx_dv(dv), .o_tx_byte(tx_byte),
      .i_tx_active(tx_active), .i_tx_done(tx_done),
      .o_grant_id(gid), .o_busy(busy), .o_timeout(to)
   );

   // Free-running clock.
   initial forever #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // ---------------- reference model (transaction level) ----------------
   int         cyc = 0;
   int         m_last = 3;
   bit         m_xfer = 1'b0;
   bit         m_settle = 1'b0;
   int         m_tgrant = 0;
   logic [7:0] m_byte = 8'h00;
   logic [1:0] m_gid = 2'd3;
   logic       m_dv = 1'b0;
   logic [3:0] m_ack = 4'b0000;
   logic       m_to = 1'b0;
   logic       m_busy = 1'b0;

   int   dv_count = 0;
   int   ack_count = 0;
   int   g_q[$];
   logic [7:0] b_q[$];
   int   t_dv_last = 0;
   int   t_to_rise = 0;
   logic prev_to = 1'b0;

   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int s = 1; s <= 4; s++) if (r[(last + s) % 4]) return (last + s) % 4;
      return 0;
   endfunction

   // One clock edge of the model: a transfer is granted, its dv/ack come one
   // cycle later, then it waits for done or TO cycles, then waits for quiet.
   task automatic model_step();
      int age;
      int w;
      m_dv  = 1'b0;
      m_ack = 4'b0000;
      if (m_xfer) begin
         age = cyc - m_tgrant;
         if (age == 1) begin
            m_dv  = 1'b1;
            m_ack = 4'(1 << m_gid);
         end else if (tx_done) begin
            m_xfer = 1'b0; m_settle = 1'b1;
         end else if (age - 1 == TO) begin
            m_to = 1'b1; m_xfer = 1'b0; m_settle = 1'b1;
         end
      end else if (m_settle) begin
         if (!tx_done && !tx_active) m_settle = 1'b0;
      end else if (req != 4'b0000 && !tx_active && !tx_done) begin
         w        = rr_pick(req, m_last);
         m_last   = w;
         m_gid    = 2'(w);
         m_byte   = 8'(data >> (8 * w));
         m_xfer   = 1'b1;
         m_tgrant = cyc;
      end
   endtask

   // Compare process: steps the model on each edge and checks every output.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         #1;
         cyc++;
         if (rst) begin
            m_last = 3; m_xfer = 1'b0; m_settle = 1'b0; m_byte = 8'h00;
            m_gid = 2'd3; m_dv = 1'b0; m_ack = 4'b0000; m_to = 1'b0;
         end else begin
            model_step();
         end
         m_busy = m_xfer || m_settle;
         check("tx_dv",    32'(dv),      32'(m_dv));
         check("ack",      32'(ack),     32'(m_ack));
         check("tx_byte",  32'(tx_byte), 32'(m_byte));
         check("grant_id", 32'(gid),     32'(m_gid));
         check("busy",     32'(busy),    32'(m_busy));
         check("timeout",  32'(to),      32'(m_to));
         if (dv === 1'b1) begin
            dv_count++;
            g_q.push_back(int'(gid));
            b_q.push_back(tx_byte);
            t_dv_last = cyc;
         end
         if (ack != 4'b0000) ack_count++;
         if (to === 1'b1 && prev_to !== 1'b1) t_to_rise = cyc;
         prev_to = to;
      end
   end

   // ---------------- transmitter model ----------------
   int tx_alen = 10;
   int tx_dlen = 2;
   bit tx_dead = 1'b0;
   bit tx_run = 1'b0;
   int tx_n = 0;

   // Busy for tx_alen cycles after a dv, then done for tx_dlen cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            tx_run = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
         end else begin
            if (dv && !tx_dead) begin tx_run = 1'b1; tx_n = 0; end
            if (tx_run) begin
               if (tx_n < tx_alen) begin tx_active = 1'b1; tx_done = 1'b0; end
               else if (tx_n < tx_alen + tx_dlen) begin tx_active = 1'b0; tx_done = 1'b1; end
               else begin tx_active = 1'b0; tx_done = 1'b0; tx_run = 1'b0; end
               tx_n++;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic reset_checks(input string tag);
      check({tag, "_dv"},   32'(dv),      32'd0);
      check({tag, "_ack"},  32'(ack),     32'd0);
      check({tag, "_byte"}, 32'(tx_byte), 32'h00);
      check({tag, "_gid"},  32'(gid),     32'd3);
      check({tag, "_busy"}, 32'(busy),    32'd0);
      check({tag, "_to"},   32'(to),      32'd0);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #2 reset_checks(tag);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int budget, input string name);
      int i;
      i = 0;
      while (ack == 4'b0000 && i < budget) begin @(negedge clk); i++; end
      check(name, 32'(ack != 4'b0000), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i;
      i = 0;
      while ((busy || tx_run) && i < budget) begin @(negedge clk); i++; end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_dv(input int target, input int budget, input string name);
      int i;
      i = 0;
      while (dv_count < target && i < budget) begin
         @(negedge clk);
         req = req & ~ack;
         i++;
      end
      check(name, 32'(dv_count >= target), 32'd1);
   endtask

   // Global time bound.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int base;
   int ackb;
   int exp_ord[5] = '{0, 1, 2, 3, 0};
   logic [7:0] exp_byte[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

   // Main stimulus sequence.
   initial begin
      #1 rst = 1'b1;
      #2 reset_checks("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single request, byte 0xA5.
      tx_alen = 10; tx_dlen = 2; tx_dead = 1'b0;
      @(negedge clk);
      base = dv_count; ackb = ack_count;
      data[7:0] = 8'hA5; req = 4'b0001;
      wait_ack(30, "single_ack_seen");
      check("single_ack", 32'(ack), 32'h1);
      check("single_byte", 32'(tx_byte), 32'hA5);
      req = 4'b0000;
      wait_idle(60, "single_idle");
      check("single_dv_pulses", 32'(dv_count - base), 32'd1);
      check("single_ack_cycles", 32'(ack_count - ackb), 32'd1);

      // All four requesting continuously from reset.
      pulse_reset("rst_a");
      data = 32'h43322110; req = 4'b1111;
      base = dv_count; ackb = ack_count;
      g_q.delete(); b_q.delete();
      while (dv_count < base + 5 && n_total < 1000000) begin
         @(negedge clk);
         if (dv_count >= base + 5) req = 4'b0000;
         if (cyc > 4000) break;
      end
      req = 4'b0000;
      check("rr_reached5", 32'(dv_count >= base + 5), 32'd1);
      wait_idle(60, "rr_idle");
      check("rr_count", 32'(g_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < g_q.size(); i++) begin
         check("rr_grant", 32'(g_q[i]), 32'(exp_ord[i]));
         check("rr_byte", 32'(b_q[i]), 32'(exp_byte[i]));
      end
      check("rr_acks", 32'(ack_count - ackb), 32'd5);

      // Done held three cycles counts once.
      tx_alen = 4; tx_dlen = 3;
      base = dv_count;
      data[23:16] = 8'h5C; req = 4'b0100;
      wait_ack(30, "long_done_ack_seen");
      check("long_done_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      wait_idle(60, "long_done_idle");
      check("long_done_pulses", 32'(dv_count - base), 32'd1);

      // Transmitter never answers: abandon after TO cycles, flag sticks.
      tx_dead = 1'b1;
      data[15:8] = 8'h7E; req = 4'b0010;
      wait_ack(30, "dead_ack_seen");
      req = 4'b0000;
      for (int i = 0; i < 40 && !to; i++) @(negedge clk);
      check("dead_timeout_set", 32'(to), 32'd1);
      check("dead_timeout_delay", 32'(t_to_rise - t_dv_last), 32'(TO));
      wait_idle(20, "dead_idle");
      tx_dead = 1'b0; tx_alen = 3; tx_dlen = 2;
      base = dv_count;
      data[7:0] = 8'h3C; req = 4'b0001;
      wait_ack(30, "after_to_ack_seen");
      check("after_to_ack", 32'(ack), 32'h1);
      check("after_to_byte", 32'(tx_byte), 32'h3C);
      req = 4'b0000;
      wait_idle(60, "after_to_idle");
      check("after_to_served", 32'(dv_count - base), 32'd1);
      check("timeout_sticky", 32'(to), 32'd1);

      // Done in exactly the last allowed cycle wins over the timeout.
      pulse_reset("rst_b");
      tx_alen = TO - 1; tx_dlen = 2;
      req = 4'b0001;
      wait_ack(30, "edge_ack_seen");
      req = 4'b0000;
      wait_idle(80, "edge_idle");
      check("edge_no_timeout", 32'(to), 32'd0);
      // One cycle later is too late.
      tx_alen = TO;
      req = 4'b0010;
      wait_ack(30, "late_ack_seen");
      req = 4'b0000;
      wait_idle(80, "late_idle");
      check("late_timeout", 32'(to), 32'd1);

      // Reset in WAIT_DONE, then requester 0 favoured over 3.
      tx_dead = 1'b1;
      req = 4'b0001;
      wait_ack(30, "midrst_ack_seen");
      req = 4'b0000;
      repeat (5) @(negedge clk);
      pulse_reset("rst_mid");
      tx_dead = 1'b0; tx_alen = 3; tx_dlen = 2;
      data = 32'h08000001; req = 4'b1001;
      g_q.delete();
      base = dv_count;
      wait_dv(base + 2, 100, "midrst_two_served");
      req = 4'b0000;
      wait_idle(60, "midrst_idle");
      check("midrst_count", 32'(g_q.size()), 32'd2);
      if (g_q.size() >= 2) begin
         check("midrst_first", 32'(g_q[0]), 32'd0);
         check("midrst_second", 32'(g_q[1]), 32'd3);
      end

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (!busy && !tx_run && $urandom_range(0, 3) == 0) begin
            tx_alen = int'($urandom_range(0, 12));
            tx_dlen = int'($urandom_range(1, 4));
            tx_dead = ($urandom_range(0, 15) == 0);
         end
         for (int k = 0; k < 4; k++) begin
            if (ack[k]) begin
               req[k] = 1'b0;
            end else if (!req[k] && $urandom_range(0, 5) == 0) begin
               req[k] = 1'b1;
               data[8 * k +: 8] = 8'($urandom);
            end else if (req[k] && busy && gid == 2'(k) && $urandom_range(0, 7) == 0) begin
               req[k] = 1'b0;
            end
         end
         if ($urandom_range(0, 499) == 0) pulse_reset("rst_rand");
      end
      req = 4'b0000;
      tx_dead = 1'b0;
      wait_idle(100, "rand_idle");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
